// File: rtl/kgp_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state encoding and
// default geometry for the PC, instruction word and return-address stack.
package kgp_fetch_pkg;

    localparam int unsigned DefPcW      = 10;
    localparam int unsigned DefInstrW   = 32;
    localparam int unsigned DefResetPc  = 0;
    localparam int unsigned DefRasDepth = 4;

    typedef enum logic [1:0] {
        StBoot,
        StRun,
        StFlush,
        StHalt
    } fetch_state_e;

endpackage

// File: rtl/ret_addr_stack.sv
// Circular return-address stack. A push when full overwrites the oldest entry;
// a pop when empty leaves the stack untouched. The caller flags both cases.
module ret_addr_stack #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 10,
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [Width-1:0] data_i,
    output logic [Width-1:0] top_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [PtrW-1:0]  ptr_o
);

    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  ptr_q, ptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [PtrW-1:0]  ptr_next, ptr_prev;

    // Pointer arithmetic modulo Depth; ptr_q is the next free slot.
    always_comb begin
        ptr_next = (ptr_q == PtrW'(Depth - 1)) ? '0 : ptr_q + PtrW'(1);
        ptr_prev = (ptr_q == '0) ? PtrW'(Depth - 1) : ptr_q - PtrW'(1);
        empty_o  = (cnt_q == '0);
        full_o   = (cnt_q == CntW'(Depth));
        top_o    = mem_q[ptr_prev];
        ptr_o    = ptr_q;
    end

    // Next pointer/occupancy; push takes precedence over pop.
    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (push_i) begin
            ptr_d = ptr_next;
            if (!full_o) cnt_d = cnt_q + CntW'(1);
        end else if (pop_i && !empty_o) begin
            ptr_d = ptr_prev;
            cnt_d = cnt_q - CntW'(1);
        end
    end

    // Pointer/occupancy state; clearing the count discards all entries.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry storage; no reset needed since occupancy gates every read.
    always_ff @(posedge clk_i) begin
        if (!rst_i && push_i) mem_q[ptr_q] <= data_i;
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the synchronous instruction
// memory and squashes the wrong-path fetch on a branch redirect.
// Optional return-address stack enabled by defining KGP_FETCH_RAS_EN.
module pc_fetch_unit
    import kgp_fetch_pkg::*;
#(
    parameter int unsigned PC_W      = DefPcW,
    parameter int unsigned INSTR_W   = DefInstrW,
    parameter int unsigned RESET_PC  = DefResetPc,
    parameter int unsigned RAS_DEPTH = DefRasDepth
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               halt,
    input  logic               pc_src,
    input  logic [PC_W-1:0]    ex_npc,
    input  logic               is_call,
    input  logic               is_ret,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [PC_W-1:0]    imem_addr,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc,
    output logic               instr_valid,
    output logic [PC_W-1:0]    link_addr,
    output logic               ras_err
);

    fetch_state_e       state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0]    instr_pc_q, instr_pc_d;
    logic               valid_q, valid_d;
    logic               accept;
    logic [PC_W-1:0]    target;

    // Redirects only from RUN on a correct-path instruction; halt and stall win.
    assign accept = (state_q == StRun) && pc_src && valid_q && !stall && !halt;

`ifdef KGP_FETCH_RAS_EN
    localparam int unsigned RasPtrW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    logic               do_call, do_ret;
    logic               ras_empty, ras_full;
    logic [PC_W-1:0]    ras_top;
    logic [RasPtrW-1:0] unused_ras_ptr;
    logic               ras_err_q, ras_err_d;

    // Call dominates when both call and return are flagged.
    assign do_call = accept && is_call;
    assign do_ret  = accept && is_ret && !is_call;

    ret_addr_stack #(
        .Depth (RAS_DEPTH),
        .Width (PC_W)
    ) u_ras (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (do_call),
        .pop_i   (do_ret),
        .data_i  (link_addr),
        .top_o   (ras_top),
        .empty_o (ras_empty),
        .full_o  (ras_full),
        .ptr_o   (unused_ras_ptr)
    );

    // Return target comes from the stack unless it has run dry.
    always_comb begin
        target    = (do_ret && !ras_empty) ? ras_top : ex_npc;
        ras_err_d = ras_err_q | (do_call && ras_full) | (do_ret && ras_empty);
    end

    // Sticky overflow/underflow flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) ras_err_q <= 1'b0;
        else     ras_err_q <= ras_err_d;
    end

    assign ras_err = ras_err_q;
`else
    logic unused_ras_in;

    assign unused_ras_in = is_call ^ is_ret;
    assign target        = ex_npc;
    assign ras_err       = 1'b0;
`endif

    // Next-state and datapath: halt > stall > redirect > sequential fetch.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        unique case (state_q)
            StBoot: begin
                state_d = StRun;
            end
            StRun, StFlush: begin
                if (halt) begin
                    state_d = StHalt;
                    valid_d = 1'b0;
                end else if (!stall) begin
                    instr_d    = imem_rdata;
                    instr_pc_d = pc_q;
                    if (accept) begin
                        // Fetch already in flight is wrong-path; mark it invalid.
                        pc_d    = target;
                        valid_d = 1'b0;
                        state_d = StFlush;
                    end else begin
                        pc_d    = pc_q + PC_W'(1);
                        valid_d = 1'b1;
                        state_d = StRun;
                    end
                end
            end
            StHalt: begin
                valid_d = 1'b0;
            end
            default: begin
                state_d = StBoot;
            end
        endcase
    end

    // Stage registers with synchronous reset to BOOT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StBoot;
            pc_q       <= PC_W'(RESET_PC);
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
        end
    end

    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = valid_q;
    assign link_addr   = instr_pc_q + PC_W'(1);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit. Memory word equals its address and is
// read on the falling edge, so it is valid at the next rising edge.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        halt = 1'b0;
    logic        pc_src = 1'b0;
    logic [9:0]  ex_npc = '0;
    logic        is_call = 1'b0;
    logic        is_ret = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [9:0]  imem_addr;
    logic [31:0] instr;
    logic [9:0]  instr_pc;
    logic        instr_valid;
    logic [9:0]  link_addr;
    logic        ras_err;

    pc_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .halt        (halt),
        .pc_src      (pc_src),
        .ex_npc      (ex_npc),
        .is_call     (is_call),
        .is_ret      (is_ret),
        .imem_rdata  (imem_rdata),
        .imem_addr   (imem_addr),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .link_addr   (link_addr),
        .ras_err     (ras_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) imem_rdata <= 32'(imem_addr);

    typedef struct packed {
        logic       v;
        logic [9:0] pc;
        logic       err;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    logic [9:0]  nxt = '0;
    logic        e_err = 1'b0;
    logic [9:0]  ret_exp [6];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic h, input logic ps,
                         input logic [9:0] npc, input logic c, input logic rt);
        rst = r; stall = s; halt = h; pc_src = ps; ex_npc = npc; is_call = c; is_ret = rt;
    endtask

    task automatic compare();
        exp_t       e;
        logic [9:0] l;
        e = sb_q.pop_front();
        check_val("instr_valid", 32'(instr_valid), 32'(e.v));
        if (e.v) begin
            l = e.pc + 10'd1;
            check_val("instr_pc", 32'(instr_pc), 32'(e.pc));
            check_val("instr", instr, 32'(e.pc));
            check_val("link_addr", 32'(link_addr), 32'(l));
        end
        check_val("ras_err", 32'(ras_err), 32'(e_err));
    endtask

    // Expectation is queued with the stimulus, checked after the edge.
    task automatic cyc(input logic v, input logic [9:0] pc);
        exp_t e;
        e.v = v; e.pc = pc; e.err = e_err;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0);
            cyc(1'b1, nxt);
            nxt = nxt + 10'd1;
        end
    endtask

    task automatic redirect(input logic [9:0] t);
        drive(1'b0, 1'b0, 1'b0, 1'b1, t, 1'b0, 1'b0);
        cyc(1'b0, 10'd0);
        nxt = t;
    endtask

    initial begin
        // Reset, then sequential fetch; pc_src is ignored in BOOT and while invalid.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0);
        cyc(1'b0, 10'd0);
        cyc(1'b0, 10'd0);
        check_val("rst_instr_pc", 32'(instr_pc), 32'd0);
        check_val("rst_instr", instr, 32'd0);
        check_val("rst_imem_addr", 32'(imem_addr), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 10'd77, 1'b0, 1'b0);
        cyc(1'b0, 10'd0);
        cyc(1'b1, 10'd0);
        nxt = 10'd1;
        idle(5);

        // Taken branch at instr_pc 5: one bubble, then the target.
        redirect(10'd40);
        idle(3);

        // Stall with a pending redirect at instr_pc 7.
        redirect(10'd5);
        idle(3);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b1, 10'd200, 1'b0, 1'b0);
            cyc(1'b1, 10'd7);
            check_val("stall_imem_addr", 32'(imem_addr), 32'd8);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1, 10'd200, 1'b0, 1'b0);
        cyc(1'b0, 10'd0);
        cyc(1'b1, 10'd200);
        nxt = 10'd201;
        idle(2);

        // PC wrap-around.
        redirect(10'd1022);
        idle(4);

        // Call at 10 to 100, return at 103.
        redirect(10'd10);
        idle(1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 10'd100, 1'b1, 1'b0);
        cyc(1'b0, 10'd0);
        nxt = 10'd100;
        idle(4);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 10'd0, 1'b0, 1'b1);
        cyc(1'b0, 10'd0);
`ifdef KGP_FETCH_RAS_EN
        nxt = 10'd11;
`else
        nxt = 10'd0;
`endif
        idle(2);

        // Five nested calls into a four-deep stack, then six returns.
        redirect(10'd500);
        idle(1);
        for (int k = 0; k < 5; k++) begin
`ifdef KGP_FETCH_RAS_EN
            if (k == 4) e_err = 1'b1;
`endif
            drive(1'b0, 1'b0, 1'b0, 1'b1, 10'(600 + 10 * k), 1'b1, 1'b0);
            cyc(1'b0, 10'd0);
            nxt = 10'(600 + 10 * k);
            idle(1);
        end
`ifdef KGP_FETCH_RAS_EN
        ret_exp[0] = 10'd631; ret_exp[1] = 10'd621; ret_exp[2] = 10'd611;
        ret_exp[3] = 10'd601; ret_exp[4] = 10'd904; ret_exp[5] = 10'd905;
`else
        for (int k = 0; k < 6; k++) ret_exp[k] = 10'(900 + k);
`endif
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, 10'(900 + k), 1'b0, 1'b1);
            cyc(1'b0, 10'd0);
            nxt = ret_exp[k];
            idle(1);
        end

        // Halt at instr_pc 3; only reset leaves it.
        redirect(10'd1);
        idle(3);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 10'd0, 1'b0, 1'b0);
        cyc(1'b0, 10'd0);
        check_val("halt_imem_addr", 32'(imem_addr), 32'd4);
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, 10'd50, 1'b0, 1'b0);
            cyc(1'b0, 10'd0);
            check_val("halt_hold_addr", 32'(imem_addr), 32'd4);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0);
        e_err = 1'b0;
        cyc(1'b0, 10'd0);
        check_val("rst2_imem_addr", 32'(imem_addr), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0);
        cyc(1'b0, 10'd0);
        nxt = 10'd0;
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
